// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM fader: FSM states, brightness width
// and the default PWM period.
package rgb_pwm_pkg;
  localparam int BRIGHT_W          = 8;
  localparam int PWM_STEPS_DEFAULT = 255;

  typedef logic [BRIGHT_W-1:0] bright_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_t;
endpackage

// File: rtl/rgb_pwm_fader_edge_sync.sv
// Brings an asynchronous square wave into the clk domain and emits a one-clk pulse
// for every rising edge seen after the synchronizer chain.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   edge_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      edge_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      edge_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_p0[SYNC_STAGES-1] & ~edge_p1;

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM LED driver with frame-paced linear fading toward loaded targets.
// Duty cycles are only refreshed at the PWM period boundary so a period never glitches.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PWM_STEPS   = PWM_STEPS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_pwm,
  input  logic       clk_60,
  input  logic [7:0] target_r,
  input  logic [7:0] target_g,
  input  logic [7:0] target_b,
  input  logic [3:0] fade_step,
  input  logic       load,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       busy,
  output logic       done
);

  localparam bright_t CNT_LAST = bright_t'(PWM_STEPS - 1);

  logic pwm_tick;
  logic frame_tick;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pwm (
    .clk      (clk),
    .reset    (reset),
    .async_in (clk_pwm),
    .pulse    (pwm_tick)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_frame (
    .clk      (clk),
    .reset    (reset),
    .async_in (clk_60),
    .pulse    (frame_tick)
  );

  bright_t           pwm_cnt;
  bright_t     [2:0] cur_q, tgt_q, duty_q;
  bright_t     [2:0] cur_d, tgt_d;
  bright_t     [2:0] tgt_in;
  logic        [3:0] step_q, step_d;
  logic        [2:0] pwm_q;
  fade_state_t       state_q, state_d;
  logic              busy_q, done_q, done_d;

  // One fade step toward the target; widened to 9 bits so neither direction can wrap.
  function automatic bright_t step_toward(input bright_t cur, input bright_t tgt,
                                          input logic [3:0] stp);
    logic [8:0] sum;
    logic [8:0] diff;
    sum  = {1'b0, cur} + {5'd0, stp};
    diff = {1'b0, cur} - {5'd0, stp};
    if (cur < tgt) return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
    if (cur > tgt) return (diff[8] || (diff[7:0] < tgt)) ? tgt : diff[7:0];
    return cur;
  endfunction

  assign tgt_in = {target_b, target_g, target_r};

  // PWM counter, period-boundary duty latch and registered comparators
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      pwm_q   <= '0;
    end else begin
      if (pwm_tick) begin
        if (pwm_cnt == CNT_LAST) begin
          pwm_cnt <= '0;
          duty_q  <= cur_q;
        end else begin
          pwm_cnt <= pwm_cnt + 8'd1;
        end
      end
      for (int c = 0; c < 3; c++) pwm_q[c] <= (pwm_cnt < duty_q[c]);
    end
  end

  assign pwm_r = pwm_q[0];
  assign pwm_g = pwm_q[1];
  assign pwm_b = pwm_q[2];

  // Fade FSM: a load always takes priority over a coincident frame step
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    done_d  = 1'b0;
    if (load) begin
      tgt_d  = tgt_in;
      step_d = fade_step;
      if (fade_step == 4'd0) begin
        cur_d   = tgt_in;
        state_d = IDLE;
      end else if (cur_q != tgt_in) begin
        state_d = FADING;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == FADING) begin
      if (cur_q == tgt_q) begin
        state_d = IDLE;
      end else if (frame_tick) begin
        for (int c = 0; c < 3; c++) cur_d[c] = step_toward(cur_q[c], tgt_q[c], step_q);
      end
    end
    done_d = (state_q == FADING) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      busy_q  <= (state_d == FADING);
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchronizer flops per async tick input (min 2).
REQ-002 SHALL have parameter PWM_STEPS, default 255, meaning PWM counter period in pwm ticks (count 0..PWM_STEPS-1).
REQ-003 SHALL have port clk  input  1  system clock (12.5 MHz).
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clk_pwm  input  1  divider PWM-rate square wave (122400 Hz); asynchronous to clk; one rising edge = one PWM step.
REQ-006 SHALL have port clk_60  input  1  divider frame-rate square wave (60 Hz); asynchronous to clk; one rising edge = one fade frame.
REQ-007 SHALL have port target_r, target_g, target_b  input  8 each  requested brightness per channel.
REQ-008 SHALL have port fade_step  input  4  brightness change per frame; 0 = immediate jump.
REQ-009 SHALL have port load  input  1  one-cycle pulse latching targets and fade_step.
REQ-010 SHALL have port pwm_r, pwm_g, pwm_b  output  1 each  registered PWM drive.
REQ-011 SHALL have port busy  output  1  high while in FADING.
REQ-012 SHALL have port done  output  1  one-cycle pulse on FADING->IDLE.

Function
REQ-013 SHALL pass clk_pwm and clk_60 through SYNC_STAGES flops each, then rising-edge detect, giving one-clk pulses pwm_tick and frame_tick.
REQ-014 SHALL increment 8-bit pwm_cnt on pwm_tick only, wrapping PWM_STEPS-1 -> 0.
REQ-015 SHALL latch active duty per channel from current brightness only on the pwm_tick that wraps pwm_cnt to 0 (glitch-free, no mid-period change).
REQ-016 SHALL drive pwm_x = (pwm_cnt < active_duty_x), registered; duty 0 -> constant low, duty 255 -> constant high.
REQ-017 SHALL implement FSM states IDLE, FADING.
REQ-018 On load: latch targets and fade_step; if fade_step==0, current <= target same cycle, stay/enter IDLE; else enter FADING if any current != target, otherwise stay IDLE with no done pulse.
REQ-019 In FADING on frame_tick: each channel moves toward its target by fade_step, saturating at target (no overshoot, no 8-bit wrap; compute in 9 bits).
REQ-020 SHALL leave FADING -> IDLE in the cycle after all three channels equal target, asserting done for exactly that one cycle.
REQ-021 load during FADING SHALL retarget without resetting current brightness; state stays FADING, or goes IDLE per REQ-018.
REQ-022 load and frame_tick in same cycle: load wins; that frame step is skipped.
REQ-023 frame_tick in IDLE SHALL have no effect; pwm_tick SHALL run in every state.
REQ-024 busy SHALL equal (state == FADING), registered.

Reset
REQ-025 On reset assertion SHALL asynchronously clear: synchronizer and edge flops, pwm_cnt, current/target/active duty, fade_step, all PWM outputs to 0, busy 0, done 0, state IDLE.
REQ-026 Reset mid-fade SHALL abandon the fade with no done pulse; first edge counted after release is the first rising edge seen post-synchronizer.

Structure
REQ-027 Shared package rgb_pwm_pkg SHALL hold the state enum (IDLE, FADING), PWM_STEPS default, and brightness width constant (8).
REQ-028 SHALL instantiate sub-module edge_sync (synchronizer + rising-edge pulse, parameter SYNC_STAGES) twice, for clk_pwm and clk_60.

Verification
REQ-029 Reset released, clk_pwm toggling, no load -> pwm_r/g/b stay 0 for 2 full periods; busy 0, done never pulses.
REQ-030 load target_r=128, target_g=0, target_b=255, fade_step=0 -> after next wrap, pwm_r high for exactly 128 of 255 ticks, pwm_g never high, pwm_b always high.
REQ-031 From 0, load target_r=10, fade_step=4 -> r after frames 1,2,3 = 4, 8, 10; done one cycle after frame 3; busy low afterwards.
REQ-032 From r=200, load target_r=3, fade_step=15 -> r descends by 15 per frame to 5, then to 3 (no underflow wrap); done once.
REQ-033 During fade, load coincident with frame_tick (target_r=50) -> no step that cycle, fade continues toward 50 from held value.
REQ-034 Change target with fade_step=0 while pwm_cnt=100 -> output pattern changes only after pwm_cnt wraps to 0; reset asserted mid-fade -> all outputs 0 immediately, state IDLE.
